// File: rtl/counter_updown.sv
// counter_updown: parametrised up/down counter with runtime direction,
// count enable, synchronous clear/load, programmable modulus (0..MAX),
// wrap or saturate at the bounds, terminal-count prediction and
// one-cycle overflow/underflow event pulses.
//
// The count register, ovf and unf are registered. tc is deliberately
// combinational so that a consumer can act in the same cycle in which the
// next edge will hit a bound.

module counter_updown #(
  parameter int unsigned N   = 2,
  parameter int unsigned MAX = (2 ** N) - 1,
  parameter bit          SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,       // asynchronous, active low
  input  logic         en,
  input  logic         up,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] out,
  output logic         tc,
  output logic         ovf,
  output logic         unf
);

  // Bounds and step constants at the counter width.
  localparam logic [N-1:0] MAX_V  = MAX[N-1:0];
  localparam logic [N-1:0] ZERO_V = '0;
  localparam logic [N-1:0] ONE_V  = N'(1'b1);

  // Load values above the modulus are pulled down to MAX so the count
  // never leaves the legal range through a load.
  function automatic logic [N-1:0] clamp_to_max(input logic [N-1:0] v);
    logic [N-1:0] res;
    if (v > MAX_V) begin
      res = MAX_V;
    end else begin
      res = v;
    end
    return res;
  endfunction

  logic [N-1:0] r_out;
  logic         r_ovf;
  logic         r_unf;

  logic [N-1:0] w_out_nxt;
  logic         w_ovf_nxt;
  logic         w_unf_nxt;
  logic         w_at_top;
  logic         w_at_zero;
  logic         w_tc;

  // Boundary detection; an out-of-range count (>MAX) is treated as MAX
  // by an up-step, while a down-step simply decrements it.
  always_comb begin
    w_at_top  = (r_out >= MAX_V);
    w_at_zero = (r_out == ZERO_V);
  end

  // Next-state selection in priority order: clear, load, step, hold.
  always_comb begin
    w_out_nxt = r_out;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    if (clear) begin
      w_out_nxt = ZERO_V;
    end else if (load) begin
      w_out_nxt = clamp_to_max(load_val);
    end else if (en) begin
      if (up) begin
        if (w_at_top) begin
          // Up-step at the top bound: wrap to 0 or stick at MAX.
          w_ovf_nxt = 1'b1;
          if (SAT) begin
            w_out_nxt = MAX_V;
          end else begin
            w_out_nxt = ZERO_V;
          end
        end else begin
          w_out_nxt = r_out + ONE_V;
        end
      end else begin
        if (w_at_zero) begin
          // Down-step at 0: wrap to MAX or stick at 0.
          w_unf_nxt = 1'b1;
          if (SAT) begin
            w_out_nxt = ZERO_V;
          end else begin
            w_out_nxt = MAX_V;
          end
        end else begin
          w_out_nxt = r_out - ONE_V;
        end
      end
    end else begin
      w_out_nxt = r_out;
    end
  end

  // Count and event-flag registers; reset clears them without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= ZERO_V;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_out <= w_out_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
    end
  end

  // Terminal count: the next enabled edge in the current direction will
  // wrap or saturate.
  always_comb begin
    w_tc = en & ((up & (r_out == MAX_V)) | (~up & (r_out == ZERO_V)));
  end

  assign out = r_out;
  assign ovf = r_ovf;
  assign unf = r_unf;
  assign tc  = w_tc;

endmodule

// File: doc/counter_updown.md
# counter_updown

Parametrised up/down counter that succeeds the fixed-direction `counter_up` and `counter_down` blocks. It adds runtime direction, count enable, synchronous clear and load, and a programmable modulus. Each boundary can either wrap or saturate, and the block reports terminal count and overflow/underflow events. It is the general counting primitive for timers, address generators and event counters in the design.

## Interface
Parameters:
- `N`, default 2: counter width in bits (N >= 1).
- `MAX`, default 2**N-1: highest count value; the count range is 0..MAX. Legal values are 1 <= MAX <= 2**N-1.
- `SAT`, default 0: boundary mode. 0 wraps around; 1 saturates at the boundary.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: asynchronous, active-low reset. Low forces all state to reset values immediately. Deassertion must be synchronised to `clk` externally.
- `en`  input  1: count enable; one step per cycle while high.
- `up`  input  1: direction. 1 counts up, 0 counts down. Sampled each cycle.
- `clear`  input  1: synchronous clear to 0.
- `load`  input  1: synchronous load of `load_val`.
- `load_val`  input  N: value to load; values above MAX are clamped to MAX.
- `out`  output  N: registered count.
- `tc`  output  1: combinational terminal count, equal to `en & ((up & out==MAX) | (~up & out==0))`.
- `ovf`  output  1: registered one-cycle pulse marking an up-step taken at MAX.
- `unf`  output  1: registered one-cycle pulse marking a down-step taken at 0.

## Operation
Reset values: `out`=0, `ovf`=0, `unf`=0. `tc` follows from state: 0 when up=1 or en=0, and 1 when en=1, up=0 and out=0.

Per-edge priority, highest first:
1. `clear`: `out`<=0; `ovf`, `unf` <= 0. Overrides load and en.
2. `load`: `out`<=min(`load_val`, MAX); `ovf`, `unf` <= 0. Overrides en.
3. `en` with `up`=1:
   - out<MAX: out<=out+1.
   - out==MAX, SAT=0: out<=0, ovf<=1.
   - out==MAX, SAT=1: out holds at MAX, ovf<=1.
4. `en` with `up`=0:
   - out>0: out<=out-1.
   - out==0, SAT=0: out<=MAX, unf<=1.
   - out==0, SAT=1: out holds at 0, unf<=1.
5. Otherwise `out` holds and `ovf`, `unf` <= 0.

Other rules:
- `ovf` and `unf` are never high in the same cycle.
- Each stays high for exactly one cycle per boundary step. Continuous stepping at a saturated bound keeps the flag high on every such cycle.
- Arithmetic is N-bit with explicit MAX compare. Increment wraps to 0 at MAX, never at 2**N-1, unless MAX=2**N-1.
- A direction change takes effect on the same edge it is sampled. There is no turnaround cycle.
- Out-of-range state (out>MAX) is unreachable. It is nonetheless defined: an up-step treats it as MAX, and a down-step decrements normally.

## Timing
- Latency: a control input sampled at edge k is visible on `out`, `ovf` and `unf` after edge k.
- `tc` is combinational from `en`, `up` and `out`. It is high in the same cycle in which the next edge will wrap or saturate, so `tc` at edge k predicts `ovf`/`unf` after edge k.
- Reset asserted mid-count: `out`, `ovf` and `unf` go to 0 asynchronously, without waiting for a clock edge.
- The first step after reset release happens on the first rising edge with `rst`=1 and `en`=1.
- Throughput: one step per cycle. There are no stall or bubble cycles.

## Test plan
- **Wrap up** (N=2, MAX=3, SAT=0): hold rst low for 25 ns, then en=1, up=1. Required: out=0,1,2,3,0,1… One-cycle `ovf` pulse after every 3→0 step; `tc`=1 whenever out=3.
- **Wrap down, same config**: up=0 from out=0. Required: out=3,2,1,0,3… `unf` pulses after every 0→3 step; `tc`=1 whenever out=0.
- **Modulus and clamp** (N=4, MAX=9): count up. Required: out=8,9,0 with `ovf` pulse. Then load=1 with load_val=13: required out=9.
- **Saturate** (N=4, MAX=9, SAT=1): load 8, then count up for 3 cycles. Required: out=9,9,9 and `ovf` high for the last 2 cycles. Then reverse from 0: out stays 0 and `unf` is high.
- **Priority**: clear=1, load=1, en=1 in the same cycle from out=5. Required: out=0. Then load=1, en=1, load_val=7. Required: out=7 with no step applied.
- **Async reset mid-count**: assert rst low between clock edges while out=6 and `ovf` is high. Required: out=0 and ovf=0 before the next edge. After release, counting restarts from 0.
